// File: rtl/collision_pkg.sv
// Shared helpers for the collision matrix.
// Holds the layer-pair index mapping and a lowest-set-bit search used by
// the event serialiser.
package collision_pkg;

  // Widest vector lowest_set() can scan; covers up to 23 layers (253 pairs).
  localparam int unsigned MaxVecW = 256;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } lowest_t;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Lexicographic index of pair (i,j), i<j.
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction

  // Scan from the top down so the lowest set bit is the last one written.
  function automatic lowest_t lowest_set(input logic [MaxVecW-1:0] vec);
    lowest_t res;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = MaxVecW - 1; k >= 0; k--) begin
      if (vec[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/collision_matrix_pending_arbiter.sv
// Pending-hit register and valid/ready event serialiser.
// Ports:
//   clk, resetN      clock, async active-low reset
//   new_hit_i        one bit per pair, newly hit this cycle
//   evt_ready_i      consumer accepts the current event
//   evt_valid_o      event available
//   evt_pair_o       pair index of the current event
//   evt_overflow_o   sticky: a hit was merged into an event not yet consumed
module pending_arbiter
  import collision_pkg::*;
#(
  parameter int NUM_PAIRS = 28,
  parameter int PAIR_W    = 5
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [NUM_PAIRS-1:0] new_hit_i,
  input  logic                 evt_ready_i,
  output logic                 evt_valid_o,
  output logic [PAIR_W-1:0]    evt_pair_o,
  output logic                 evt_overflow_o
);

  logic [NUM_PAIRS-1:0] pending_q, pending_d;
  logic                 valid_q, valid_d;
  logic [PAIR_W-1:0]    pair_q, pair_d;
  logic                 overflow_q, overflow_d;

  lowest_t              sel;
  logic                 load;
  logic [NUM_PAIRS-1:0] clr_mask;
  logic [NUM_PAIRS-1:0] held_mask;
  logic [NUM_PAIRS-1:0] merged;

  always_comb begin
    sel       = lowest_set(MaxVecW'(pending_q));
    load      = (!valid_q || evt_ready_i) && sel.found;
    clr_mask  = '0;
    held_mask = '0;
    if (load) begin
      clr_mask[PAIR_W'(sel.idx)] = 1'b1;
    end
    // An event sitting unconsumed in the output register is still pending
    // for that pair; a repeat hit folds into it instead of queueing again.
    if (valid_q && !evt_ready_i) begin
      held_mask[pair_q] = 1'b1;
    end
    merged = new_hit_i & (pending_q | held_mask);

    // Set wins over the clear of the bit being loaded.
    pending_d  = (pending_q & ~clr_mask) | (new_hit_i & ~held_mask);
    overflow_d = overflow_q | (|merged);

    valid_d = valid_q;
    pair_d  = pair_q;
    if (load) begin
      valid_d = 1'b1;
      pair_d  = PAIR_W'(sel.idx);
    end else if (valid_q && evt_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_q  <= '0;
      valid_q    <= 1'b0;
      pair_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      pair_q     <= pair_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid_o    = valid_q;
  assign evt_pair_o     = pair_q;
  assign evt_overflow_o = overflow_q;

endmodule

// File: rtl/collision_matrix.sv
// Per-frame collision detector across drawing-request layers.
// Ports:
//   clk, resetN            clock, async active-low reset
//   startOfFrame           one-cycle frame-start pulse
//   layerDR                per-layer drawing request
//   pairEnable             per-pair runtime enable
//   collisionNow           combinational pairwise overlap
//   hitPulse, anyHitPulse  first hit per pair / of any pair this frame
//   frameHits              pairs hit during the previous frame
//   evtValid/evtPair/evtReady  serialised hit events
//   evtOverflow            sticky merge flag
module collision_matrix
  import collision_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int NUM_PAIRS  = num_pairs(NUM_LAYERS),
  parameter int PAIR_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [NUM_LAYERS-1:0] layerDR,
  input  logic [NUM_PAIRS-1:0]  pairEnable,
  output logic [NUM_PAIRS-1:0]  collisionNow,
  output logic [NUM_PAIRS-1:0]  hitPulse,
  output logic                  anyHitPulse,
  output logic [NUM_PAIRS-1:0]  frameHits,
  output logic                  evtValid,
  output logic [PAIR_W-1:0]     evtPair,
  input  logic                  evtReady,
  output logic                  evtOverflow
);

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_row
    for (genvar j = i + 1; j < NUM_LAYERS; j++) begin : g_col
      localparam int P = pair_index(i, j, NUM_LAYERS);
      assign collisionNow[P] = layerDR[i] & layerDR[j] & pairEnable[P];
    end
  end

  logic [NUM_PAIRS-1:0] hit_flags_q, hit_flags_d;
  logic [NUM_PAIRS-1:0] hit_pulse_q;
  logic [NUM_PAIRS-1:0] frame_hits_q, frame_hits_d;
  logic [NUM_PAIRS-1:0] new_hit;
  logic                 any_flag_q, any_flag_d;
  logic                 any_pulse_q;
  logic                 any_new;

  // Start of frame clears the semaphores first; a same-cycle hit then sets
  // them again and belongs to the new frame.
  always_comb begin
    new_hit      = collisionNow & (~hit_flags_q | {NUM_PAIRS{startOfFrame}});
    hit_flags_d  = (startOfFrame ? '0 : hit_flags_q) | new_hit;
    any_new      = (|collisionNow) & (!any_flag_q || startOfFrame);
    any_flag_d   = (startOfFrame ? 1'b0 : any_flag_q) | any_new;
    frame_hits_d = startOfFrame ? hit_flags_q : frame_hits_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_flags_q  <= '0;
      hit_pulse_q  <= '0;
      frame_hits_q <= '0;
      any_flag_q   <= 1'b0;
      any_pulse_q  <= 1'b0;
    end else begin
      hit_flags_q  <= hit_flags_d;
      hit_pulse_q  <= new_hit;
      frame_hits_q <= frame_hits_d;
      any_flag_q   <= any_flag_d;
      any_pulse_q  <= any_new;
    end
  end

  assign hitPulse    = hit_pulse_q;
  assign anyHitPulse = any_pulse_q;
  assign frameHits   = frame_hits_q;

  pending_arbiter #(
    .NUM_PAIRS (NUM_PAIRS),
    .PAIR_W    (PAIR_W)
  ) u_arbiter (
    .clk            (clk),
    .resetN         (resetN),
    .new_hit_i      (new_hit),
    .evt_ready_i    (evtReady),
    .evt_valid_o    (evtValid),
    .evt_pair_o     (evtPair),
    .evt_overflow_o (evtOverflow)
  );

endmodule

// File: tb/tb_collision_matrix.sv
module tb_collision_matrix;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic [3:0] layerDR;
  logic [5:0] pairEnable;
  logic [5:0] collisionNow;
  logic [5:0] hitPulse;
  logic       anyHitPulse;
  logic [5:0] frameHits;
  logic       evtValid;
  logic [2:0] evtPair;
  logic       evtReady;
  logic       evtOverflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  collision_matrix #(
    .NUM_LAYERS (4)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .layerDR      (layerDR),
    .pairEnable   (pairEnable),
    .collisionNow (collisionNow),
    .hitPulse     (hitPulse),
    .anyHitPulse  (anyHitPulse),
    .frameHits    (frameHits),
    .evtValid     (evtValid),
    .evtPair      (evtPair),
    .evtReady     (evtReady),
    .evtOverflow  (evtOverflow)
  );

  typedef struct {
    logic [3:0] dr;
    logic [5:0] en;
    logic [5:0] exp_cn;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0011, 6'h3F, 6'h01};
    vecs[1] = '{4'b0110, 6'h3F, 6'h08};
    vecs[2] = '{4'b1100, 6'h3F, 6'h20};
    vecs[3] = '{4'b0101, 6'h3F, 6'h02};
    vecs[4] = '{4'b1010, 6'h3F, 6'h10};
    vecs[5] = '{4'b1001, 6'h3F, 6'h04};
    vecs[6] = '{4'b1111, 6'h3F, 6'h3F};
    vecs[7] = '{4'b1111, 6'h15, 6'h15};
    vecs[8] = '{4'b0111, 6'h3F, 6'h0B};
    vecs[9] = '{4'b0001, 6'h3F, 6'h00};

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    layerDR      = '0;
    pairEnable   = 6'h3F;
    evtReady     = 1'b1;
    #12;

    check("rst_hitPulse", 32'(hitPulse), 0);
    check("rst_anyHit", 32'(anyHitPulse), 0);
    check("rst_frameHits", 32'(frameHits), 0);
    check("rst_evtValid", 32'(evtValid), 0);
    check("rst_evtPair", 32'(evtPair), 0);
    check("rst_overflow", 32'(evtOverflow), 0);

    // Combinational pair map, exercised while registers are held in reset.
    for (int k = 0; k < 10; k++) begin
      layerDR    = vecs[k].dr;
      pairEnable = vecs[k].en;
      #1;
      check($sformatf("collisionNow[%0d]", k), 32'(collisionNow), 32'(vecs[k].exp_cn));
    end
    layerDR    = '0;
    pairEnable = 6'h3F;
    #1;
    resetN = 1'b1;
    tick();

    // Layers 0,1 overlap for 5 cycles.
    sof();
    layerDR = 4'b0011;
    tick();
    check("s1_hitPulse_t1", 32'(hitPulse), 32'h01);
    check("s1_any_t1", 32'(anyHitPulse), 1);
    check("s1_valid_t1", 32'(evtValid), 0);
    tick();
    check("s1_hitPulse_t2", 32'(hitPulse), 0);
    check("s1_any_t2", 32'(anyHitPulse), 0);
    check("s1_valid_t2", 32'(evtValid), 1);
    check("s1_pair_t2", 32'(evtPair), 0);
    tick();
    check("s1_valid_t3", 32'(evtValid), 0);
    check("s1_hitPulse_t3", 32'(hitPulse), 0);
    tick();
    layerDR = '0;
    tick();
    check("s1_valid_t5", 32'(evtValid), 0);
    sof();
    check("s1_frameHits", 32'(frameHits), 32'h01);

    // Pair 0 then pair 5 three cycles later.
    layerDR = 4'b0011;
    tick();
    layerDR = '0;
    check("s2_hit0", 32'(hitPulse), 32'h01);
    check("s2_any0", 32'(anyHitPulse), 1);
    tick();
    check("s2_pair0", 32'(evtPair), 0);
    tick();
    layerDR = 4'b1100;
    tick();
    layerDR = '0;
    check("s2_hit5", 32'(hitPulse), 32'h20);
    check("s2_any5", 32'(anyHitPulse), 0);
    tick();
    check("s2_valid5", 32'(evtValid), 1);
    check("s2_pair5", 32'(evtPair), 5);
    tick();
    check("s2_drained", 32'(evtValid), 0);

    // All layers at once: six back-to-back events.
    sof();
    layerDR = 4'b1111;
    tick();
    layerDR = '0;
    check("s3_hitPulse", 32'(hitPulse), 32'h3F);
    tick();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("s3_valid%0d", k), 32'(evtValid), 1);
      check($sformatf("s3_pair%0d", k), 32'(evtPair), 32'(k));
      tick();
    end
    check("s3_drained", 32'(evtValid), 0);

    // Pair 3 hit in two frames with the consumer stalled.
    sof();
    evtReady = 1'b0;
    layerDR  = 4'b0110;
    tick();
    layerDR = '0;
    tick();
    check("s4_valid_a", 32'(evtValid), 1);
    check("s4_pair_a", 32'(evtPair), 3);
    check("s4_ovf_a", 32'(evtOverflow), 0);
    tick();
    tick();
    sof();
    layerDR = 4'b0110;
    tick();
    layerDR = '0;
    check("s4_hit3", 32'(hitPulse), 32'h08);
    check("s4_ovf_b", 32'(evtOverflow), 1);
    tick();
    check("s4_valid_b", 32'(evtValid), 1);
    check("s4_pair_b", 32'(evtPair), 3);
    evtReady = 1'b1;
    tick();
    check("s4_single_evt", 32'(evtValid), 0);
    tick();
    check("s4_still_empty", 32'(evtValid), 0);

    // Collision coincident with start of frame; then back-to-back frames.
    startOfFrame = 1'b1;
    layerDR      = 4'b0110;
    tick();
    startOfFrame = 1'b0;
    layerDR      = '0;
    check("s5_hit3", 32'(hitPulse), 32'h08);
    check("s5_any", 32'(anyHitPulse), 1);
    check("s5_frameHits", 32'(frameHits), 32'h08);
    sof();
    check("s5_frameHits_b2b1", 32'(frameHits), 32'h08);
    sof();
    check("s5_frameHits_b2b2", 32'(frameHits), 32'h00);
    tick();
    check("s5_evt_drained", 32'(evtValid), 0);

    // Disabled pair produces nothing.
    pairEnable = 6'h3E;
    layerDR    = 4'b0011;
    #1;
    check("s6_collisionNow", 32'(collisionNow), 0);
    tick();
    check("s6_hitPulse", 32'(hitPulse), 0);
    check("s6_any", 32'(anyHitPulse), 0);
    tick();
    tick();
    check("s6_valid", 32'(evtValid), 0);
    layerDR    = '0;
    pairEnable = 6'h3F;

    // Async reset mid-handshake.
    evtReady = 1'b0;
    layerDR  = 4'b1100;
    tick();
    layerDR      = '0;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("s7_valid_pre", 32'(evtValid), 1);
    check("s7_pair_pre", 32'(evtPair), 5);
    check("s7_frame_pre", 32'(frameHits), 32'h20);
    #2;
    resetN = 1'b0;
    #1;
    check("s7_valid", 32'(evtValid), 0);
    check("s7_pair", 32'(evtPair), 0);
    check("s7_frameHits", 32'(frameHits), 0);
    check("s7_overflow", 32'(evtOverflow), 0);
    check("s7_hitPulse", 32'(hitPulse), 0);
    check("s7_any", 32'(anyHitPulse), 0);
    #10;
    resetN = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/collision_matrix.md
# collision_matrix

- Parametrised per-frame collision detector for the VGA game pipeline.
- Takes one drawing-request bit per object layer and detects every overlap between pairs of layers that are enabled.
- Per enabled pair, produces one hit pulse per frame, plus one "any hit" pulse per frame and a latched summary of the previous frame's hits.
- Serialises new hits into a valid/ready event stream that game logic consumes one pair at a time.

## Interface
Parameters:
- NUM_LAYERS, 8, number of drawing-request inputs (min 2).
- NUM_PAIRS, NUM_LAYERS*(NUM_LAYERS-1)/2, derived; not overridden.
- PAIR_W, $clog2(NUM_PAIRS), width of a pair index (min 1).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- layerDR  in  NUM_LAYERS  per-layer drawing request for the current pixel.
- pairEnable  in  NUM_PAIRS  runtime mask; bit p=0 ignores pair p entirely.
- collisionNow  out  NUM_PAIRS  combinational; layerDR[i] & layerDR[j] & pairEnable[p].
- hitPulse  out  NUM_PAIRS  registered; first collision of pair p in the current frame.
- anyHitPulse  out  1  registered; first collision of any enabled pair in the frame.
- frameHits  out  NUM_PAIRS  registered set of pairs hit during the previous frame.
- evtValid  out  1  event available.
- evtPair  out  PAIR_W  index of the hit pair.
- evtReady  in  1  consumer accepts the event.
- evtOverflow  out  1  sticky flag; a hit was merged into a still-pending event.

## Operation
- Pair index for layers (i,j) with i<j uses lexicographic order: p = i*NUM_LAYERS − i*(i+1)/2 + (j−i−1).
- hitFlags[p] is a per-frame semaphore.
  - startOfFrame clears all flags.
  - A collision in the same cycle sets the flag afterwards, so the set wins and the hit belongs to the new frame.
- New hit: collisionNow[p] & (!hitFlags[p] | startOfFrame). On a new hit, the next edge does:
  - hitFlags[p]<=1.
  - hitPulse[p]<=1 for one cycle.
  - pending[p]<=1.
- anyHitPulse follows the same semaphore over the OR of all pairs. It fires at most once per frame even if several pairs are hit.
- On startOfFrame, frameHits<=hitFlags, taking the value before this cycle's hits. frameHits holds until the next startOfFrame.
- Event serialiser:
  - The output register loads when !evtValid | evtReady and pending≠0.
  - It takes the lowest set pending index and clears that bit.
  - If that same bit is newly hit in the same cycle, the set wins and the bit stays pending.
  - If evtValid & evtReady and pending=0, evtValid drops to 0.
- pending is not cleared by startOfFrame; events survive frame boundaries.
- A new hit on pair p while pending[p] is already 1 sets evtOverflow. evtOverflow clears only on reset.
- Clearing a pairEnable bit does not retract pending or flagged hits; it only blocks new ones.
- Async reset clears everything, including mid-handshake: hitFlags, pending, hitPulse, anyHitPulse, frameHits, evtValid, evtPair=0, evtOverflow.

## Timing
- Reset value of every registered output is 0. collisionNow follows its inputs.
- Collision in cycle t:
  - hitPulse and anyHitPulse are high in cycle t+1.
  - Earliest evtValid is cycle t+2.
- Throughput is one event per cycle while evtReady=1.
- With k pairs newly hit in one cycle, the events appear over k consecutive accepted handshakes in ascending index order.
- While evtValid=1 and evtReady=0, evtPair is held stable.
- startOfFrame is not required to be periodic. Two back-to-back startOfFrame pulses are legal; the second copies an empty or near-empty flag set into frameHits.

## Structure
- Package collision_pkg holds:
  - function num_pairs(n).
  - function pair_index(i,j,n).
  - function lowest_set(vector) returning an index and a found bit.
- The pair mapping is generated with a generate loop over i<j, using pair_index.
- Sub-module pending_arbiter holds the pending register, the lowest-index select and the output register with the valid/ready logic.
- The top level holds the semaphores, pulses and frameHits.

## Test plan
All scenarios use NUM_LAYERS=4 (6 pairs; (0,1)=0, (1,2)=3, (2,3)=5) and pairEnable=6'h3F unless stated.
- Layers 0 and 1 high for 5 cycles mid-frame -> hitPulse[0] and anyHitPulse each pulse once, 1 cycle after the first overlap. One event with evtPair=0. At the next startOfFrame, frameHits=6'h01.
- Layers 0 and 1 high in cycle t, then layers 2 and 3 high in cycle t+3, same frame -> hitPulse[0] at t+1 and hitPulse[5] at t+4; anyHitPulse only at t+1.
- All layers high for one cycle with evtReady=1 -> hitPulse=6'h3F. Events 0,1,2,3,4,5 on 6 consecutive cycles starting 2 cycles after the overlap.
- evtReady held 0 while pair 3 is hit in two successive frames -> a single event with evtPair=3 is held stable, and evtOverflow=1.
- Collision on the same cycle as startOfFrame, pair 3 also hit in the prior frame -> hitPulse[3] fires, and frameHits contains bit 3 from the prior frame only.
- pairEnable=6'h3E with layers 0 and 1 high -> no pulse and no event. Assert resetN low while evtValid=1 -> all outputs read 0 asynchronously.
